// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core.
// Sequences the shared ALU, the shared memory port, the instruction register
// and the immediate extender. It stalls on the MemReady handshake.
// Optional feature macro: CTRL_PERF_CNT_EN adds the CycleCnt and InstRet
// performance counters.
module riscv_multicycle_ctrl #(
  parameter int RESET_STATE_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic       IllegalInstr
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] CycleCnt,
  output logic [31:0] InstRet
`endif
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_LUI,
    S_ILLEGAL
  } state_t;

  localparam int HOLD_W = (RESET_STATE_HOLD > 0) ? $clog2(RESET_STATE_HOLD + 1) : 1;

  state_t            state;
  state_t            next_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_active;
  logic              branch_ok;
  logic              illegal_q;
  logic              unused_funct7b5;

  // Funct7b5 is consumed by the ALU decoder, not by this FSM
  assign unused_funct7b5 = Funct7b5;

  assign hold_active  = (hold_cnt != '0);
  assign branch_ok    = (Funct3[2:1] == 2'b00);
  assign IllegalInstr = illegal_q;

  // Next-state selection
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (!hold_active && MemReady) next_state = S_DECODE;
      S_DECODE: begin
        case (Op)
          7'b0000011, 7'b0100011: next_state = S_MEMADR;
          7'b0110011:             next_state = S_EXECR;
          7'b0010011:             next_state = S_EXECI;
          7'b1100011:             next_state = S_BRANCH;
          7'b1101111:             next_state = S_JAL;
          7'b0110111:             next_state = S_LUI;
          default:                next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR: next_state = Op[5] ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (MemReady) next_state = S_MEMWB;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  if (MemReady) next_state = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_LUI: next_state = S_ALUWB;
      S_ALUWB:  next_state = S_FETCH;
      S_BRANCH: next_state = branch_ok ? S_FETCH : S_ILLEGAL;
      S_ILLEGAL: next_state = S_ILLEGAL;
      default:  next_state = S_FETCH;
    endcase
  end

  // Datapath controls decoded from the state; IRWrite/PCWrite also see MemReady or Zero
  always_comb begin
    MemReq    = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ImmSrc    = 3'b000;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    ResultSrc = 2'b00;
    case (state)
      S_FETCH: begin
        if (!hold_active) begin
          MemReq    = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = MemReady;
          PCWrite   = MemReady;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b011;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = Op[5] ? 3'b010 : 3'b000;
      end
      S_MEMRD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWR: begin
        MemReq   = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = branch_ok & (Zero ^ Funct3[0]);
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        ImmSrc  = 3'b100;
      end
      S_LUI: begin
        ImmSrc  = 3'b001;
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      default: ;
    endcase
  end

  // State register, post-reset hold counter, sticky illegal flag and optional counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      hold_cnt  <= HOLD_W'(RESET_STATE_HOLD);
      illegal_q <= 1'b0;
`ifdef CTRL_PERF_CNT_EN
      CycleCnt  <= 32'd0;
      InstRet   <= 32'd0;
`endif
    end else begin
      state <= next_state;
      if (state == S_FETCH && hold_active) hold_cnt <= hold_cnt - 1'b1;
      if (next_state == S_ILLEGAL) illegal_q <= 1'b1;
`ifdef CTRL_PERF_CNT_EN
      if (state != S_ILLEGAL) begin
        CycleCnt <= CycleCnt + 32'd1;
        if (next_state == S_FETCH &&
            (state == S_MEMWB || state == S_MEMWR || state == S_ALUWB || state == S_BRANCH))
          InstRet <= InstRet + 32'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Self-checking bench for riscv_multicycle_ctrl: table vectors, directed
// multi-cycle sequences and randomized instructions against a per-instruction
// expected-cycle model.
module tb_riscv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] Op = 7'h00;
  logic [2:0] Funct3 = 3'b000;
  logic       Funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       MemReq, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, IllegalInstr;
  logic [2:0] ImmSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] CycleCnt, InstRet;
`endif

  riscv_multicycle_ctrl #(.RESET_STATE_HOLD(1)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct3(Funct3), .Funct7b5(Funct7b5),
    .Zero(Zero), .MemReady(MemReady), .MemReq(MemReq), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ResultSrc(ResultSrc), .IllegalInstr(IllegalInstr)
`ifdef CTRL_PERF_CNT_EN
    , .CycleCnt(CycleCnt), .InstRet(InstRet)
`endif
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        zero;
    logic        ready;
    logic [17:0] exp;
  } step_t;

  int    checks = 0;
  int    errors = 0;
  step_t q[$];
  step_t lwTab[5];
  logic [17:0] outs;

  assign outs = {MemReq, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ImmSrc,
                 ALUSrcA, ALUSrcB, ALUOp, ResultSrc, IllegalInstr};

  function automatic logic [17:0] mk(input logic mreq, input logic adr, input logic ir,
                                     input logic pc, input logic mw, input logic rw,
                                     input logic [2:0] imm, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] aop,
                                     input logic [1:0] res, input logic ill);
    return {mreq, adr, ir, pc, mw, rw, imm, a, b, aop, res, ill};
  endfunction

  task automatic checkOutput(input string name, input logic [17:0] exp);
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, outs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic zero, input logic ready);
    @(negedge clk);
    Op       = op;
    Funct3   = f3;
    Funct7b5 = 1'($urandom);
    Zero     = zero;
    MemReady = ready;
    #1;
  endtask

  task automatic push(input logic [6:0] op, input logic [2:0] f3, input logic zero,
                      input logic ready, input logic [17:0] exp);
    step_t s;
    s.op = op; s.f3 = f3; s.zero = zero; s.ready = ready; s.exp = exp;
    q.push_back(s);
  endtask

  task automatic runQueue(input string name);
    for (int i = 0; i < q.size(); i++) begin
      applyStimulus(q[i].op, q[i].f3, q[i].zero, q[i].ready);
      checkOutput($sformatf("%s[%0d]", name, i), q[i].exp);
    end
    q.delete();
  endtask

  // Expected cycle-by-cycle controls of one instruction, from fetch to its last cycle
  task automatic modelInstr(input logic [6:0] op, input logic [2:0] f3, input logic zero,
                            input int fetchStall, input int memStall, output bit endsIllegal);
    logic [17:0] aluwb   = mk(0,0,0,0,0,1,3'b000,2'b00,2'b00,2'b00,2'b00,0);
    logic [17:0] illegal = mk(0,0,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,1);
    endsIllegal = 1'b0;
    for (int i = 0; i < fetchStall; i++)
      push(op, f3, 1'($urandom), 1'b0, mk(1,0,0,0,0,0,3'b000,2'b00,2'b10,2'b00,2'b10,0));
    push(op, f3, 1'($urandom), 1'b1, mk(1,0,1,1,0,0,3'b000,2'b00,2'b10,2'b00,2'b10,0));
    push(op, f3, 1'($urandom), 1'($urandom), mk(0,0,0,0,0,0,3'b011,2'b01,2'b01,2'b00,2'b00,0));
    case (op)
      7'b0000011: begin
        push(op, f3, 1'($urandom), 1'($urandom), mk(0,0,0,0,0,0,3'b000,2'b10,2'b01,2'b00,2'b00,0));
        for (int i = 0; i < memStall; i++)
          push(op, f3, 1'($urandom), 1'b0, mk(1,1,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,0));
        push(op, f3, 1'($urandom), 1'b1, mk(1,1,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,0));
        push(op, f3, 1'($urandom), 1'($urandom), mk(0,0,0,0,0,1,3'b000,2'b00,2'b00,2'b00,2'b01,0));
      end
      7'b0100011: begin
        push(op, f3, 1'($urandom), 1'($urandom), mk(0,0,0,0,0,0,3'b010,2'b10,2'b01,2'b00,2'b00,0));
        for (int i = 0; i <= memStall; i++)
          push(op, f3, 1'($urandom), (i == memStall), mk(1,1,0,0,1,0,3'b000,2'b00,2'b00,2'b00,2'b00,0));
      end
      7'b0110011: begin
        push(op, f3, 1'($urandom), 1'($urandom), mk(0,0,0,0,0,0,3'b000,2'b10,2'b00,2'b10,2'b00,0));
        push(op, f3, 1'($urandom), 1'($urandom), aluwb);
      end
      7'b0010011: begin
        push(op, f3, 1'($urandom), 1'($urandom), mk(0,0,0,0,0,0,3'b000,2'b10,2'b01,2'b10,2'b00,0));
        push(op, f3, 1'($urandom), 1'($urandom), aluwb);
      end
      7'b0110111: begin
        push(op, f3, 1'($urandom), 1'($urandom), mk(0,0,0,0,0,0,3'b001,2'b10,2'b01,2'b00,2'b00,0));
        push(op, f3, 1'($urandom), 1'($urandom), aluwb);
      end
      7'b1101111: begin
        push(op, f3, 1'($urandom), 1'($urandom), mk(0,0,0,1,0,0,3'b100,2'b01,2'b10,2'b00,2'b00,0));
        push(op, f3, 1'($urandom), 1'($urandom), aluwb);
      end
      7'b1100011: begin
        if (f3 == 3'b000 || f3 == 3'b001) begin
          push(op, f3, zero, 1'($urandom),
               mk(0,0,0,(zero != f3[0]),0,0,3'b000,2'b10,2'b00,2'b01,2'b00,0));
        end else begin
          push(op, f3, zero, 1'($urandom), mk(0,0,0,0,0,0,3'b000,2'b10,2'b00,2'b01,2'b00,0));
          push(op, f3, 1'($urandom), 1'($urandom), illegal);
          endsIllegal = 1'b1;
        end
      end
      default: begin
        push(op, f3, 1'($urandom), 1'($urandom), illegal);
        endsIllegal = 1'b1;
      end
    endcase
  endtask

  // Reset held for one edge, then released into the single post-reset hold cycle
  task automatic doReset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput({name, "_in_reset"}, 18'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput({name, "_hold"}, 18'd0);
  endtask

  // Safety net so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    bit ill;
    logic [6:0] ops[8];
    lwTab[0] = '{7'h03, 3'b010, 1'b0, 1'b1, mk(1,0,1,1,0,0,3'b000,2'b00,2'b10,2'b00,2'b10,0)};
    lwTab[1] = '{7'h03, 3'b010, 1'b0, 1'b1, mk(0,0,0,0,0,0,3'b011,2'b01,2'b01,2'b00,2'b00,0)};
    lwTab[2] = '{7'h03, 3'b010, 1'b0, 1'b1, mk(0,0,0,0,0,0,3'b000,2'b10,2'b01,2'b00,2'b00,0)};
    lwTab[3] = '{7'h03, 3'b010, 1'b0, 1'b1, mk(1,1,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,0)};
    lwTab[4] = '{7'h03, 3'b010, 1'b0, 1'b1, mk(0,0,0,0,0,1,3'b000,2'b00,2'b00,2'b00,2'b01,0)};
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h37, 7'h73};

    doReset("reset");

    for (int i = 0; i < 5; i++) begin
      applyStimulus(lwTab[i].op, lwTab[i].f3, lwTab[i].zero, lwTab[i].ready);
      checkOutput($sformatf("lw_table[%0d]", i), lwTab[i].exp);
    end

    modelInstr(7'h23, 3'b010, 1'b0, 0, 3, ill);
    runQueue("sw_stall3");
    modelInstr(7'h63, 3'b000, 1'b1, 0, 0, ill);
    runQueue("beq_taken");
    modelInstr(7'h63, 3'b000, 1'b0, 0, 0, ill);
    runQueue("beq_not_taken");
    modelInstr(7'h63, 3'b001, 1'b0, 0, 0, ill);
    runQueue("bne_taken");
    modelInstr(7'h6F, 3'b000, 1'b0, 0, 0, ill);
    runQueue("jal");
    modelInstr(7'h33, 3'b000, 1'b0, 5, 0, ill);
    runQueue("fetch_stall5");

    modelInstr(7'h73, 3'b000, 1'b0, 0, 0, ill);
    for (int i = 0; i < 10; i++)
      push(7'h73, 3'b000, 1'($urandom), 1'($urandom), mk(0,0,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,1));
    runQueue("illegal_hold");

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_mid_cycle", 18'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("async_reset_hold", 18'd0);

    for (int n = 0; n < 80; n++) begin
      logic [6:0] op;
      logic [2:0] f3;
      op = ops[$urandom_range(0, 7)];
      f3 = 3'($urandom);
      if (op != 7'h63 && $urandom_range(0, 3) != 0) f3 = 3'b010;
      if (op == 7'h63 && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 1));
      modelInstr(op, f3, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), ill);
      runQueue($sformatf("rand%0d_op%h", n, op));
      if (ill) doReset($sformatf("rand%0d_reset", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
